// File: rtl/cache_2way_wb_ctrl.sv
// 2-way set-associative write-back / write-allocate cache controller.
// Byte-wide CPU port, one-word-per-beat memory port, true per-set LRU, flush and hit/miss counters.
module cache_2way_wb_ctrl #(
  parameter int AWIDTH      = 12,
  parameter int DWIDTH      = 8,
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [2:0]        dbg_state
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int TAG_W = AWIDTH - IDX_W - OFF_W;
  localparam int LOC_W = 1 + IDX_W + OFF_W;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOOKUP     = 3'd1;
  localparam logic [2:0] S_WRITEBACK  = 3'd2;
  localparam logic [2:0] S_REFILL     = 3'd3;
  localparam logic [2:0] S_COMPLETE   = 3'd4;
  localparam logic [2:0] S_FLUSH_SCAN = 3'd5;
  localparam logic [2:0] S_FLUSH_WB   = 3'd6;

  logic [2:0]        state;
  logic [TAG_W-1:0]  req_tag;
  logic [OFF_W-1:0]  req_off;
  logic              req_we;
  logic [DWIDTH-1:0] req_wdata;
  logic [IDX_W-1:0]  cur_set;
  logic              cur_way;
  logic [OFF_W-1:0]  beat;

  logic [NUM_SETS-1:0] valid_q [2];
  logic [NUM_SETS-1:0] dirty_q [2];
  logic [NUM_SETS-1:0] lru_q;
  logic [TAG_W-1:0]    tag_q   [2][NUM_SETS];
  logic [DWIDTH-1:0]   data_q  [2**LOC_W];

  logic              hit0, hit1, hit, hit_way, victim, victim_dirty;
  logic              beat_ack, last_beat, wb_state;
  logic              data_we, tag_we;
  logic [LOC_W-1:0]  data_waddr;
  logic [DWIDTH-1:0] data_wdata;

  assign dbg_state = state;
  assign cpu_busy  = (state != S_IDLE);
  assign wb_state  = (state == S_WRITEBACK) || (state == S_FLUSH_WB);
  assign beat_ack  = mem_req && mem_ack;
  assign last_beat = &beat;

  always_comb begin
    hit0    = valid_q[0][cur_set] && (tag_q[0][cur_set] == req_tag);
    hit1    = valid_q[1][cur_set] && (tag_q[1][cur_set] == req_tag);
    hit     = hit0 || hit1;
    hit_way = !hit0;
    if (!valid_q[0][cur_set])
      victim = 1'b0;
    else if (!valid_q[1][cur_set])
      victim = 1'b1;
    else
      victim = lru_q[cur_set];
    victim_dirty = valid_q[victim][cur_set] && dirty_q[victim][cur_set];
  end

  // Memory handshake: a beat transfers on a rising clock edge where mem_req and mem_ack
  // are both high; mem_req, mem_we, mem_addr and mem_wdata hold steady until that edge.
  always_comb begin
    mem_we    = mem_req && wb_state;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wb_state) begin
      mem_addr  = {tag_q[cur_way][cur_set], cur_set, beat};
      mem_wdata = data_q[{cur_way, cur_set, beat}];
    end else if (state == S_REFILL) begin
      mem_addr  = {req_tag, cur_set, beat};
    end
  end

  always_comb begin
    data_we    = 1'b0;
    data_waddr = '0;
    data_wdata = '0;
    tag_we     = 1'b0;
    if (state == S_REFILL && beat_ack) begin
      data_we    = 1'b1;
      data_waddr = {cur_way, cur_set, beat};
      data_wdata = mem_rdata;
      tag_we     = last_beat;
    end else if (state == S_LOOKUP && hit && req_we) begin
      data_we    = 1'b1;
      data_waddr = {hit_way, cur_set, req_off};
      data_wdata = req_wdata;
    end else if (state == S_COMPLETE && req_we) begin
      data_we    = 1'b1;
      data_waddr = {cur_way, cur_set, req_off};
      data_wdata = req_wdata;
    end
  end

  // Line data and tags are not reset; valid bits gate every use of them.
  always_ff @(posedge clock) begin
    if (data_we)
      data_q[data_waddr] <= data_wdata;
    if (tag_we)
      tag_q[cur_way][cur_set] <= req_tag;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      req_tag    <= '0;
      req_off    <= '0;
      req_we     <= 1'b0;
      req_wdata  <= '0;
      cur_set    <= '0;
      cur_way    <= 1'b0;
      beat       <= '0;
      lru_q      <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      flush_done <= 1'b0;
      mem_req    <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      for (int w = 0; w < 2; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      cpu_ready  <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush_req) begin
            cur_set <= '0;
            cur_way <= 1'b0;
            state   <= S_FLUSH_SCAN;
          end else if (cpu_req) begin
            req_tag   <= cpu_addr[AWIDTH-1 -: TAG_W];
            cur_set   <= cpu_addr[OFF_W +: IDX_W];
            req_off   <= cpu_addr[OFF_W-1:0];
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (req_we)
              dirty_q[hit_way][cur_set] <= 1'b1;
            else
              cpu_rdata <= data_q[{hit_way, cur_set, req_off}];
            lru_q[cur_set] <= ~hit_way;
            if (!(&hit_cnt))
              hit_cnt <= hit_cnt + 1'b1;
            cpu_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            if (!(&miss_cnt))
              miss_cnt <= miss_cnt + 1'b1;
            cur_way <= victim;
            beat    <= '0;
            mem_req <= 1'b1;
            state   <= victim_dirty ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (beat_ack) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              mem_req <= 1'b0;
              state   <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          // Entered from WRITEBACK with mem_req low: that cycle is the gap between bursts.
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (beat_ack) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              valid_q[cur_way][cur_set] <= 1'b1;
              dirty_q[cur_way][cur_set] <= 1'b0;
              mem_req <= 1'b0;
              state   <= S_COMPLETE;
            end
          end
        end
        S_COMPLETE: begin
          if (req_we)
            dirty_q[cur_way][cur_set] <= 1'b1;
          else
            cpu_rdata <= data_q[{cur_way, cur_set, req_off}];
          lru_q[cur_set] <= ~cur_way;
          cpu_ready      <= 1'b1;
          state          <= S_IDLE;
        end
        S_FLUSH_SCAN: begin
          if (valid_q[cur_way][cur_set] && dirty_q[cur_way][cur_set]) begin
            beat    <= '0;
            mem_req <= 1'b1;
            state   <= S_FLUSH_WB;
          end else if (cur_way && (&cur_set)) begin
            flush_done <= 1'b1;
            state      <= S_IDLE;
          end else begin
            cur_way <= ~cur_way;
            if (cur_way)
              cur_set <= cur_set + 1'b1;
          end
        end
        S_FLUSH_WB: begin
          // Returns to the same entry; now clean, the scan advances past it next cycle.
          if (beat_ack) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              dirty_q[cur_way][cur_set] <= 1'b0;
              mem_req <= 1'b0;
              state   <= S_FLUSH_SCAN;
            end
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
